// File: rtl/ps2_tx_if.sv
// Host-side command/status bundle for the PS/2 transmitter.
// wr_ps2/din form a one-cycle strobe that is accepted only while tx_idle=1.
// There is no back-pressure: a strobe presented while tx_idle=0 is simply dropped.
interface ps2_tx_if;
   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err_tick;
   logic       ack_ok;
   logic [2:0] dbg_state;

   modport master (
      output wr_ps2, din,
      input  tx_idle, tx_done_tick, tx_err_tick, ack_ok, dbg_state
   );

   modport slave (
      input  wr_ps2, din,
      output tx_idle, tx_done_tick, tx_err_tick, ack_ok, dbg_state
   );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// The block inhibits the clock line (request-to-send) and drives a start bit.
// It then shifts out 8 data bits LSB first and an odd-parity bit, releases both lines
// and samples the device acknowledge. Both lines are open-drain: the block only ever
// pulls them low or leaves them high-Z. A watchdog aborts the frame when the device
// stops clocking.
module ps2_tx #(
   parameter int RTS_CYCLES     = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic     clk,
   input  logic     reset,
   ps2_tx_if.slave  bus,
   inout  wire      ps2c,
   inout  wire      ps2d
);
   localparam int RTS_W = $clog2(RTS_CYCLES + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RTS   = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         filter_q, filter_d;
   logic               fclk_q, fclk_d;
   logic               fall_edge;
   logic [8:0]         sreg_q, sreg_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [RTS_W-1:0]   rts_cnt_q, rts_cnt_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;
   logic               ack_q, ack_d;
   logic               c_low, d_low;
   logic               done_tick, err_tick;

   // Debounce the raw clock line: the filtered level changes only after 8 agreeing samples.
   always_comb begin
      filter_d = {ps2c, filter_q[7:1]};
      fclk_d   = fclk_q;
      if (filter_d == 8'hFF)
         fclk_d = 1'b1;
      else if (filter_d == 8'h00)
         fclk_d = 1'b0;
   end

   assign fall_edge = fclk_q & ~fclk_d;

   // State, datapath and filter registers; async reset releases both lines at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         filter_q  <= 8'h00;
         fclk_q    <= 1'b0;
         sreg_q    <= 9'd0;
         bit_cnt_q <= 4'd0;
         rts_cnt_q <= '0;
         wdog_q    <= '0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         filter_q  <= filter_d;
         fclk_q    <= fclk_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         rts_cnt_q <= rts_cnt_d;
         wdog_q    <= wdog_d;
         ack_q     <= ack_d;
      end
   end

   // Next-state, line drive and tick generation; falling edges during RTS are our own and ignored.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      rts_cnt_d = rts_cnt_q;
      wdog_d    = wdog_q;
      ack_d     = ack_q;
      c_low     = 1'b0;
      d_low     = 1'b0;
      done_tick = 1'b0;
      err_tick  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.wr_ps2) begin
               sreg_d    = {~^bus.din, bus.din};
               rts_cnt_d = RTS_W'(RTS_CYCLES - 1);
               state_d   = RTS;
            end
         end
         RTS: begin
            c_low = 1'b1;
            if (rts_cnt_q == '0) begin
               wdog_d  = '0;
               state_d = START;
            end else begin
               rts_cnt_d = rts_cnt_q - 1'b1;
            end
         end
         START: begin
            d_low = 1'b1;
            if (fall_edge) begin
               bit_cnt_d = 4'd8;
               wdog_d    = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            d_low = ~sreg_q[0];
            if (fall_edge) begin
               sreg_d = {1'b0, sreg_q[8:1]};
               wdog_d = '0;
               if (bit_cnt_q == 4'd0)
                  state_d = STOP;
               else
                  bit_cnt_d = bit_cnt_q - 1'b1;
            end
         end
         STOP: begin
            if (fall_edge) begin
               ack_d     = ~ps2d;
               done_tick = 1'b1;
               wdog_d    = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Watchdog: a falling edge in the same cycle takes priority over expiry.
      if ((state_q == START || state_q == DATA || state_q == STOP) && !fall_edge) begin
         if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wdog_d   = '0;
            err_tick = 1'b1;
            state_d  = IDLE;
         end else begin
            wdog_d = wdog_q + 1'b1;
         end
      end
   end

   assign ps2c = c_low ? 1'b0 : 1'bz;
   assign ps2d = d_low ? 1'b0 : 1'bz;

   assign bus.tx_idle      = (state_q == IDLE);
   assign bus.tx_done_tick = done_tick;
   assign bus.tx_err_tick  = err_tick;
   assign bus.ack_ok       = ack_q;
   assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx. The stimulus pushes the expected outcome of each frame into exp_q.
// An independent monitor pops an entry on every done/err tick. A behavioural device
// model clocks the bus and records the bits it sees.
module tb_ps2_tx;
  localparam int RTS  = 50;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset;
  wire  ps2c;
  wire  ps2d;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx_if bus ();

  ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ps2c  (ps2c),
    .ps2d  (ps2d)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: {is_err, expected ack_ok, expected 11-bit frame as sampled by the device}
  logic [12:0] exp_q[$];
  logic [12:0] item;
  logic [10:0] dev_frame;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // monitor: compare every completion/abort tick against the head of the queue
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (bus.tx_done_tick === 1'b1 || bus.tx_err_tick === 1'b1)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_tick: done=%0b err=%0b with nothing expected",
                   bus.tx_done_tick, bus.tx_err_tick);
        end else begin
          item = exp_q.pop_front();
          check("tick_kind", 32'({bus.tx_err_tick, bus.tx_done_tick}),
                item[12] ? 32'd2 : 32'd1);
          if (!item[12]) check("frame_bits", 32'(dev_frame), 32'(item[10:0]));
          @(negedge clk);
          check("ack_ok", 32'(bus.ack_ok), 32'(item[11]));
          check("tick_one_cycle", 32'({bus.tx_err_tick, bus.tx_done_tick}), 32'd0);
        end
      end
    end
  end

  // issue a write strobe, then measure how long the host holds the clock low
  task automatic pulse_wr(input logic [7:0] d);
    int lows;
    @(negedge clk);
    bus.wr_ps2 = 1'b1;
    bus.din    = d;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    check("rts_latency", 32'(ps2c), 32'd0);
    lows = 0;
    while (ps2c === 1'b0 && lows < RTS + 100) begin
      lows++;
      @(negedge clk);
    end
    check("rts_low_cycles", 32'(lows), 32'(RTS));
  endtask

  // device model: samples ps2d just before each falling edge it generates
  task automatic device(input int nedges, input bit ack, input bit glitch, input bit inject);
    dev_frame = '0;
    for (int e = 0; e < nedges; e++) begin
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (glitch && e == 5 && k == 5) dev_c_low = 1'b1;
        if (glitch && e == 5 && k == 10) dev_c_low = 1'b0;
        if (inject && e == 4 && k == 2) begin
          bus.wr_ps2 = 1'b1;
          bus.din    = 8'h55;
        end else begin
          bus.wr_ps2 = 1'b0;
        end
      end
      dev_frame[e] = ps2d;
      if (e == 10 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
    end
    repeat (4) @(negedge clk);
    dev_d_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch, input bit inject,
                           input logic [10:0] exp_frame);
    int w;
    exp_q.push_back({1'b0, ack, exp_frame});
    pulse_wr(d);
    device(11, ack, glitch, inject);
    w = 0;
    while (bus.tx_idle !== 1'b1 && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("back_to_idle", 32'(bus.tx_idle), 32'd1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int w;
    reset      = 1'b0;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx_idle", 32'(bus.tx_idle), 32'd1);
    check("reset_done", 32'(bus.tx_done_tick), 32'd0);
    check("reset_err", 32'(bus.tx_err_tick), 32'd0);
    check("reset_ack", 32'(bus.ack_ok), 32'd0);
    check("reset_ps2c", 32'(ps2c), 32'd1);
    check("reset_ps2d", 32'(ps2d), 32'd1);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // frame = {stop=1, parity=~^din, din, start=0}
    run_frame(8'hF4, 1'b1, 1'b0, 1'b0, 11'h5E8);   // parity 0 (five ones)
    run_frame(8'h00, 1'b0, 1'b0, 1'b0, 11'h600);   // parity 1, no device ack
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 11'h7FE);   // parity 1, short clock glitch in DATA
    run_frame(8'hF4, 1'b1, 1'b0, 1'b1, 11'h5E8);   // stray write of 0x55 mid-frame

    // device stops after 4 edges: watchdog abort, ack_ok keeps its previous value
    exp_q.push_back({1'b1, 1'b1, 11'h000});
    pulse_wr(8'hA5);
    device(4, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (bus.tx_idle !== 1'b1 && w < TMO + 500) begin
      w++;
      @(negedge clk);
    end
    check("timeout_idle", 32'(bus.tx_idle), 32'd1);
    check("timeout_window", 32'((w > TMO - 100) && (w < TMO + 100)), 32'd1);
    check("timeout_ps2c", 32'(ps2c), 32'd1);
    check("timeout_ps2d", 32'(ps2d), 32'd1);
    repeat (20) @(negedge clk);

    // async reset in the middle of DATA releases the lines without a clock edge
    pulse_wr(8'h00);
    device(4, 1'b0, 1'b0, 1'b0);
    check("mid_data_drive", 32'(ps2d), 32'd0);
    check("mid_data_state", 32'(bus.dbg_state), 32'd3);
    reset = 1'b0;
    #1;
    check("rst_ps2c", 32'(ps2c), 32'd1);
    check("rst_ps2d", 32'(ps2d), 32'd1);
    check("rst_idle", 32'(bus.tx_idle), 32'd1);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_ack", 32'(bus.ack_ok), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
